// File: rtl/inst_req_scheduler_pkg.sv
// Shared CPU types for the instruction-fetch request scheduler.
package inst_req_scheduler_pkg;

  typedef logic [31:0] virt_t;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StAddrFlush
  } inst_req_state_t;

  localparam int unsigned INST_REQ_MAX_OUTSTANDING_DEFAULT = 2;

endpackage

// File: rtl/inst_req_scheduler_if.sv
// ICache address/data handshake between the fetch scheduler (master) and the ICache (slave).
interface inst_req_scheduler_if;

  logic                         icache_req;
  inst_req_scheduler_pkg::virt_t icache_addr;
  logic                         icache_addr_ok;
  logic                         icache_data_ok;

  modport master (
    output icache_req,
    output icache_addr,
    input  icache_addr_ok,
    input  icache_data_ok
  );

  modport slave (
    input  icache_req,
    input  icache_addr,
    output icache_addr_ok,
    output icache_data_ok
  );

endinterface

// File: rtl/inst_req_tracker.sv
// Live/stale outstanding-pair counters; stale pairs always return ahead of live ones.
module inst_req_tracker #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             live_inc,
  input  logic             stale_inc,
  input  logic             data_ok,
  output logic [CNT_W-1:0] inflight,
  output logic [CNT_W-1:0] cancel_cnt,
  output logic             can_issue,
  output logic             resp_valid,
  output logic             drop
);

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] cancel_q, cancel_d;
  logic [CNT_W:0]   occupancy;
  logic             hit_stale, hit_live;

  assign hit_stale = data_ok && (cancel_q != '0);
  assign hit_live  = data_ok && (cancel_q == '0) && (inflight_q != '0);

  assign occupancy = {1'b0, inflight_q} + {1'b0, cancel_q};
  assign can_issue = occupancy < (CNT_W + 1)'(MAX_OUTSTANDING);

  assign resp_valid = hit_live && !flush;
  assign drop       = hit_stale || (hit_live && flush);

  always_comb begin
    inflight_d = inflight_q;
    cancel_d   = cancel_q;
    if (flush) begin
      // Everything live becomes stale, including a pair whose address lands this cycle.
      inflight_d = '0;
      cancel_d   = cancel_q + inflight_q + CNT_W'(live_inc) + CNT_W'(stale_inc)
                   - CNT_W'(hit_live) - CNT_W'(hit_stale);
    end else begin
      inflight_d = inflight_q + CNT_W'(live_inc) - CNT_W'(hit_live);
      cancel_d   = cancel_q + CNT_W'(stale_inc) - CNT_W'(hit_stale);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= '0;
      cancel_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      cancel_q   <= cancel_d;
    end
  end

  assign inflight   = inflight_q;
  assign cancel_cnt = cancel_q;

  no_orphan_data_ok: assert property (@(posedge clk) disable iff (reset)
    !(data_ok && (inflight_q == '0) && (cancel_q == '0)));

endmodule

// File: rtl/inst_req_scheduler.sv
// Issues prefetch pairs onto the ICache handshake and drops stale returns after a flush.
// Optional perf counters are built when INST_REQ_PERF_EN is defined.
module inst_req_scheduler
  import inst_req_scheduler_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = INST_REQ_MAX_OUTSTANDING_DEFAULT,
  parameter int unsigned CNT_W           = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       req_valid,
  input  virt_t                      req_pc,
  input  logic                       req_ex,
  output logic                       req_ready,
  input  logic                       fq_allowin,
  inst_req_scheduler_if.master       icache,
  output logic                       resp_valid,
  output logic                       resp_ex,
  output logic                       busy,
  output logic [31:0]                perf_cancel,
  output logic [31:0]                perf_stall
);

  inst_req_state_t  state_q, state_d;
  virt_t            addr_q, addr_d;
  logic             resp_ex_q, resp_ex_d;
  logic             live_inc, stale_inc;
  logic             can_issue, issue, drop;
  logic [CNT_W-1:0] inflight, cancel_cnt;
  logic [2:0]       unused_pc_lo;

  assign unused_pc_lo = req_pc[2:0];

  inst_req_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .live_inc   (live_inc),
    .stale_inc  (stale_inc),
    .data_ok    (icache.icache_data_ok),
    .inflight   (inflight),
    .cancel_cnt (cancel_cnt),
    .can_issue  (can_issue),
    .resp_valid (resp_valid),
    .drop       (drop)
  );

  assign issue = req_valid && fq_allowin && !flush && can_issue;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    resp_ex_d = 1'b0;
    req_ready = 1'b0;
    live_inc  = 1'b0;
    stale_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (issue && !req_ex) begin
          req_ready = 1'b1;
          addr_d    = {req_pc[31:3], 3'b000};
          state_d   = StAddr;
        end else if (issue && req_ex && (inflight == '0)) begin
          // Exception pairs wait for live pairs so completions stay in order.
          req_ready = 1'b1;
          resp_ex_d = 1'b1;
        end
      end
      StAddr: begin
        if (icache.icache_addr_ok) begin
          live_inc  = !flush;
          stale_inc = flush;
          state_d   = StIdle;
        end else if (flush) begin
          state_d = StAddrFlush;
        end
      end
      StAddrFlush: begin
        // The request stays up until accepted; the pair is already stale.
        if (icache.icache_addr_ok) begin
          stale_inc = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      resp_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      resp_ex_q <= resp_ex_d;
    end
  end

  assign icache.icache_req  = (state_q != StIdle);
  assign icache.icache_addr = addr_q;
  assign resp_ex            = resp_ex_q;
  assign busy               = (inflight != '0) || (cancel_cnt != '0) || (state_q != StIdle);

`ifdef INST_REQ_PERF_EN
  logic [31:0] perf_cancel_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cancel_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (drop) begin
        perf_cancel_q <= perf_cancel_q + 32'd1;
      end
      if ((state_q != StIdle) && !icache.icache_addr_ok) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_cancel = perf_cancel_q;
  assign perf_stall  = perf_stall_q;
`else
  logic unused_drop;

  assign unused_drop = drop;
  assign perf_cancel = '0;
  assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_inst_req_scheduler.sv
// Directed bench for inst_req_scheduler (default MAX_OUTSTANDING = 2).
module tb_inst_req_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ex;
  logic        req_ready;
  logic        fq_allowin;
  logic        resp_valid;
  logic        resp_ex;
  logic        busy;
  logic [31:0] perf_cancel;
  logic [31:0] perf_stall;

  int total  = 0;
  int passed = 0;

`ifdef INST_REQ_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  inst_req_scheduler_if ic ();

  inst_req_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_pc      (req_pc),
    .req_ex      (req_ex),
    .req_ready   (req_ready),
    .fq_allowin  (fq_allowin),
    .icache      (ic.master),
    .resp_valid  (resp_valid),
    .resp_ex     (resp_ex),
    .busy        (busy),
    .perf_cancel (perf_cancel),
    .perf_stall  (perf_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_pc = '0; req_ex = 1'b0;
    fq_allowin = 1'b0; ic.icache_addr_ok = 1'b0; ic.icache_data_ok = 1'b0;
    tick(); tick(); settle();
    check("rst_icache_req", ic.icache_req, 0);
    check("rst_icache_addr", ic.icache_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_ex", resp_ex, 0);
    check("rst_perf_cancel", perf_cancel, 0);
    check("rst_perf_stall", perf_stall, 0);
    reset = 1'b0;
    tick();

    // Single fetch
    req_valid = 1'b1; req_pc = 32'hBFC0_0004; fq_allowin = 1'b1; settle();
    check("t1_req_ready", req_ready, 1);
    tick(); req_valid = 1'b0; settle();
    check("t1_icache_req", ic.icache_req, 1);
    check("t1_icache_addr", ic.icache_addr, 32'hBFC0_0000);
    check("t1_busy", busy, 1);
    tick(); ic.icache_addr_ok = 1'b1; settle();
    check("t1_req_held", ic.icache_req, 1);
    tick(); ic.icache_addr_ok = 1'b0; settle();
    check("t1_req_dropped", ic.icache_req, 0);
    check("t1_inflight", dut.inflight, 1);
    tick(); ic.icache_data_ok = 1'b1; settle();
    check("t1_resp_valid", resp_valid, 1);
    tick(); ic.icache_data_ok = 1'b0; settle();
    check("t1_resp_idle", resp_valid, 0);
    check("t1_busy_clear", busy, 0);

    // Fetch-queue back-pressure
    req_valid = 1'b1; req_pc = 32'h0000_1238; fq_allowin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t4_no_ready", req_ready, 0);
      check("t4_no_req", ic.icache_req, 0);
      tick();
    end
    fq_allowin = 1'b1; settle();
    check("t4_ready", req_ready, 1);
    tick(); req_valid = 1'b0; ic.icache_addr_ok = 1'b1; settle();
    check("t4_icache_req", ic.icache_req, 1);
    check("t4_icache_addr", ic.icache_addr, 32'h0000_1238 & 32'hFFFF_FFF8);
    tick(); ic.icache_addr_ok = 1'b0; settle();
    check("t4_inflight", dut.inflight, 1);

    // Exception pair held off behind a live pair
    req_valid = 1'b1; req_ex = 1'b1; req_pc = 32'h0000_2000; settle();
    check("t5_held", req_ready, 0);
    tick(); settle();
    check("t5_still_held", req_ready, 0);
    tick(); ic.icache_data_ok = 1'b1; settle();
    check("t5_live_resp", resp_valid, 1);
    check("t5_held_on_data", req_ready, 0);
    tick(); ic.icache_data_ok = 1'b0; settle();
    check("t5_accept", req_ready, 1);
    check("t5_resp_ex_early", resp_ex, 0);
    tick(); req_valid = 1'b0; req_ex = 1'b0; settle();
    check("t5_resp_ex", resp_ex, 1);
    check("t5_no_icache", ic.icache_req, 0);
    tick(); settle();
    check("t5_resp_ex_pulse", resp_ex, 0);
    check("t5_busy", busy, 0);

    // Flush with two pairs in flight
    req_valid = 1'b1; req_pc = 32'h0000_0100; settle();
    check("t2_ready0", req_ready, 1);
    tick(); ic.icache_addr_ok = 1'b1; settle();
    check("t2_no_accept_in_addr", req_ready, 0);
    tick(); ic.icache_addr_ok = 1'b0; req_pc = 32'h0000_0108; settle();
    check("t2_ready1", req_ready, 1);
    tick(); ic.icache_addr_ok = 1'b1; settle();
    check("t2_addr1", ic.icache_addr, 32'h0000_0108);
    tick(); ic.icache_addr_ok = 1'b0; req_pc = 32'h0000_0110; settle();
    check("t2_full", req_ready, 0);
    check("t2_inflight2", dut.inflight, 2);
    flush = 1'b1;
    tick(); flush = 1'b0; req_valid = 1'b0; settle();
    check("t2_cancel2", dut.cancel_cnt, 2);
    check("t2_inflight0", dut.inflight, 0);
    check("t2_busy", busy, 1);
    ic.icache_data_ok = 1'b1; settle();
    check("t2_drop0", resp_valid, 0);
    tick(); settle();
    check("t2_drop1", resp_valid, 0);
    tick(); ic.icache_data_ok = 1'b0; settle();
    check("t2_cancel0", dut.cancel_cnt, 0);
    req_valid = 1'b1; req_pc = 32'h0000_0200; settle();
    check("t2_post_ready", req_ready, 1);
    tick(); req_valid = 1'b0; ic.icache_addr_ok = 1'b1; settle();
    check("t2_post_addr", ic.icache_addr, 32'h0000_0200);
    tick(); ic.icache_addr_ok = 1'b0; ic.icache_data_ok = 1'b1; settle();
    check("t2_post_resp", resp_valid, 1);
    tick(); ic.icache_data_ok = 1'b0; settle();
    check("t2_busy_clear", busy, 0);

    // Flush while waiting on addr_ok
    req_valid = 1'b1; req_pc = 32'h0040_0010; settle();
    check("t3_ready", req_ready, 1);
    tick(); req_valid = 1'b0; flush = 1'b1; settle();
    check("t3_req_on_flush", ic.icache_req, 1);
    tick(); flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t3_req_stable", ic.icache_req, 1);
      check("t3_addr_stable", ic.icache_addr, 32'h0040_0010);
      tick();
    end
    ic.icache_addr_ok = 1'b1; settle();
    check("t3_req_at_ok", ic.icache_req, 1);
    tick(); ic.icache_addr_ok = 1'b0; settle();
    check("t3_cancel1", dut.cancel_cnt, 1);
    check("t3_inflight0", dut.inflight, 0);
    check("t3_req_low", ic.icache_req, 0);
    ic.icache_data_ok = 1'b1; settle();
    check("t3_drop", resp_valid, 0);
    tick(); ic.icache_data_ok = 1'b0; settle();
    check("t3_busy_clear", busy, 0);

    // Flush and data_ok together with two live pairs
    req_valid = 1'b1; req_pc = 32'h0000_0300; settle();
    check("t6_ready0", req_ready, 1);
    tick(); ic.icache_addr_ok = 1'b1; req_pc = 32'h0000_0308;
    tick(); ic.icache_addr_ok = 1'b0; settle();
    check("t6_ready1", req_ready, 1);
    tick(); ic.icache_addr_ok = 1'b1; req_valid = 1'b0;
    tick(); ic.icache_addr_ok = 1'b0; settle();
    check("t6_inflight2", dut.inflight, 2);
    flush = 1'b1; ic.icache_data_ok = 1'b1; settle();
    check("t6_resp_blocked", resp_valid, 0);
    tick(); flush = 1'b0; ic.icache_data_ok = 1'b0; settle();
    check("t6_cancel1", dut.cancel_cnt, 1);
    check("t6_inflight0", dut.inflight, 0);
    ic.icache_data_ok = 1'b1; settle();
    check("t6_drop", resp_valid, 0);
    tick(); ic.icache_data_ok = 1'b0; settle();
    check("t6_busy_clear", busy, 0);
    // Drops: 2 (t2) + 1 (t3) + 2 (t6); stalls: 1 (t1) + 4 (t3)
    check("perf_cancel", perf_cancel, PerfEn ? 32'd5 : 32'd0);
    check("perf_stall", perf_stall, PerfEn ? 32'd5 : 32'd0);

    // Reset mid-handshake abandons the request
    req_valid = 1'b1; req_pc = 32'h0000_0400;
    tick(); req_valid = 1'b0; settle();
    check("rst2_req_up", ic.icache_req, 1);
    reset = 1'b1;
    tick(); reset = 1'b0; settle();
    check("rst2_req_low", ic.icache_req, 0);
    check("rst2_addr", ic.icache_addr, 0);
    check("rst2_perf_cancel", perf_cancel, 0);
    check("rst2_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
